output_fn_beh: RTL and testbench



---
 rtl/output_fn_pkg.sv | 54 +++++
 rtl/output_fn_beh.sv | 48 ++++
 tb/tb_output_fn_beh.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/output_fn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : output_fn_pkg
// Purpose  : State type, default pattern and next-state table builder for
//            the overlapping serial sequence detector.
// Revision : 1.0
// ============================================================================
package output_fn_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

    // Longest proper prefix of pat that is a suffix of (first cur bits of pat, then b).
    function automatic logic [1:0] next_prefix(input logic [3:0] pat, input int cur,
                                               input logic b);
        logic [4:0] s;
        logic [3:0] mask;
        logic [3:0] head;
        logic [1:0] res;
        res  = 2'b00;
        s    = {1'b0, pat} >> (4 - cur);
        s    = {s[3:0], b};
        for (int len = 1; len <= 3; len++) begin
            if (len <= cur + 1) begin
                mask = 4'((1 << len) - 1);
                head = pat >> (4 - len);
                if ((s[3:0] & mask) == (head & mask)) begin
                    res = len[1:0];
                end
            end
        end
        return res;
    endfunction

    // Packed table: entry index {state, inp}, two bits per entry.
    function automatic logic [15:0] build_next_table(input logic [3:0] pat);
        logic [15:0] tbl;
        tbl = '0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 2; b++) begin
                tbl[(k * 2 + b) * 2 +: 2] = next_prefix(pat, k, b[0]);
            end
        end
        return tbl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_fn_beh.sv
`default_nettype none
// ============================================================================
// Module   : output_fn_beh
// Purpose  : Overlapping 4-bit serial sequence detector with registered pulse.
// Revision : 1.0
// ============================================================================
module output_fn_beh
    import output_fn_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN
) (
    output logic [1:0] state,
    output logic       out,
    input  logic       inp,
    input  logic       rst,
    input  logic       clk
);

    localparam logic [15:0] NEXT_TBL = build_next_table(PATTERN);

    state_e     state_q;
    state_e     state_d;
    logic       out_q;
    logic       out_d;
    logic [3:0] tbl_idx;

    always_comb begin
        tbl_idx = {state_q, inp, 1'b0};
        state_d = state_e'(NEXT_TBL[tbl_idx +: 2]);
        // A match completes only from the full 3-bit prefix with the final bit.
        out_d   = (state_q == S3) && (inp == PATTERN[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign state = state_q;
    assign out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_output_fn_beh.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_fn_beh
// Purpose  : Self-checking bench for output_fn_beh (patterns 1101 and 1001).
// Revision : 1.0
// ============================================================================
module tb_output_fn_beh;

    localparam logic [3:0] PAT_A = 4'b1101;
    localparam logic [3:0] PAT_B = 4'b1001;

    logic       clk;
    logic       rst;
    logic       inp;
    logic [1:0] state_a;
    logic       out_a;
    logic [1:0] state_b;
    logic       out_b;

    int n_tests;
    int n_fail;

    bit q_a[$];
    bit q_b[$];

    output_fn_beh #(.PATTERN(PAT_A)) u_dut_a (
        .state (state_a),
        .out   (out_a),
        .inp   (inp),
        .rst   (rst),
        .clk   (clk)
    );

    output_fn_beh #(.PATTERN(PAT_B)) u_dut_b (
        .state (state_b),
        .out   (out_b),
        .inp   (inp),
        .rst   (rst),
        .clk   (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Do the last len bits of the stream equal the first len bits of pat?
    function automatic bit tail_matches(input bit q[$], input logic [3:0] pat, input int len);
        int n;
        n = q.size();
        if (n < len) return 1'b0;
        for (int i = 0; i < len; i++) begin
            if (q[n - len + i] != pat[3 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int ref_state(input bit q[$], input logic [3:0] pat);
        for (int len = 3; len >= 1; len--) begin
            if (tail_matches(q, pat, len)) return len;
        end
        return 0;
    endfunction

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        inp = b;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            q_a.delete();
            q_b.delete();
        end else begin
            q_a.push_back(b);
            q_b.push_back(b);
        end
        check("state_a", 32'(state_a), 32'(ref_state(q_a, PAT_A)));
        check("out_a",   32'(out_a),   32'(tail_matches(q_a, PAT_A, 4)));
        check("state_b", 32'(state_b), 32'(ref_state(q_b, PAT_B)));
        check("out_b",   32'(out_b),   32'(tail_matches(q_b, PAT_B, 4)));
    endtask

    initial begin
        logic [15:0] seq;
        int          exp2 [16];
        logic [6:0]  ovl;
        logic [6:0]  pb;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        inp     = 1'b1;

        // Reset held for two edges with inp high.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            check("rst_state", 32'(state_a), 32'd0);
            check("rst_out",   32'(out_a),   32'd0);
        end

        // Directed stream, LSB first, with the literal state trace.
        seq  = 16'b0010001110110010;
        exp2 = '{0, 1, 0, 0, 1, 2, 3, 1, 2, 2, 3, 0, 0, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step(seq[i], 1'b0);
            check("seq_state", 32'(state_a), 32'(exp2[i]));
            check("seq_out",   32'(out_a),   (i == 7) ? 32'd1 : 32'd0);
        end

        // Overlapping matches: 1,1,0,1,1,0,1.
        step(1'b0, 1'b1);
        ovl = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            step(ovl[i], 1'b0);
            check("ovl_out", 32'(out_a), (i == 3 || i == 6) ? 32'd1 : 32'd0);
            if (i == 3) check("ovl_state", 32'(state_a), 32'd1);
        end

        // All-ones stream never detects and parks in S2.
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            check("ones_state", 32'(state_a), (i == 0) ? 32'd1 : 32'd2);
            check("ones_out",   32'(out_a),   32'd0);
        end

        // Reset in the middle of a partial match.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_state", 32'(state_a), 32'd0);
        step(1'b1, 1'b0);
        check("midrst_state1", 32'(state_a), 32'd1);
        check("midrst_out",    32'(out_a),   32'd0);

        // Pattern 1001: 1,0,0,1,0,0,1.
        step(1'b0, 1'b1);
        pb = 7'b1001001;
        for (int i = 0; i < 7; i++) begin
            step(pb[i], 1'b0);
            check("p1001_out", 32'(out_b), (i == 3 || i == 6) ? 32'd1 : 32'd0);
        end

        // Random stream with occasional resets.
        step(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(39, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
